// File: rtl/cdnsusbhs_adma_buf_ctrl_pkg.sv
// Shared ADMA buffer defaults and types. The RAM wrapper sources the same
// address width and depth so both sides always agree on the buffer geometry.
package cdnsusbhs_adma_buf_ctrl_pkg;

  localparam int unsigned ADMA_ADDR_WIDTH   = 7;
  localparam int unsigned ADMA_DATA_WIDTH   = 32;
  localparam int unsigned ADMA_MEMORY_DEPTH = 1 << ADMA_ADDR_WIDTH;
  localparam int unsigned OBUF_DEPTH        = 2;

  typedef enum logic [1:0] {
    RAM_IDLE  = 2'd0,
    RAM_WRITE = 2'd1,
    RAM_READ  = 2'd2
  } ram_op_e;

endpackage

// File: rtl/cdnsusbhs_adma_buf_obuf.sv
// Two-entry output buffer that hides the one-cycle RAM read latency.
// Push and pop in the same cycle are both honoured; flush wins over both.
module cdnsusbhs_adma_buf_obuf #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;
  logic                  do_pop, do_push;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    do_pop  = pop && (occ_q != 2'd0);
    // A push into a full buffer is only legal when the head leaves that cycle
    do_push = push && ((occ_q != 2'd2) || do_pop);
    if (flush) begin
      occ_d = 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (occ_q == 2'd0) head_d = push_data;
          else               tail_d = push_data;
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            head_d = push_data;
          end else begin
            head_d = tail_q;
            tail_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign occ  = occ_q;
  assign head = head_q;

endmodule

// File: rtl/cdnsusbhs_adma_buf_ctrl.sv
// ADMA data-buffer controller: runs an external single-port RAM as a circular
// FIFO, one access per cycle with reads first, and streams out through a 2-entry buffer.
module cdnsusbhs_adma_buf_ctrl
  import cdnsusbhs_adma_buf_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADMA_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = ADMA_DATA_WIDTH,
  parameter int unsigned MEMORY_DEPTH = ADMA_MEMORY_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ready,
  input  logic                  flush,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  output logic                  ram_en,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMORY_DEPTH - 1);
  localparam logic [CW-1:0]         DEPTH_CNT = CW'(MEMORY_DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, addr_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic [CW-1:0]         ram_count_q, ram_count_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [1:0]            obuf_occ;
  logic                  pop, rd_issue, wr_accept;
  ram_op_e               ram_op;

  assign rd_valid = (obuf_occ != 2'd0);
  assign full     = (ram_count_q == DEPTH_CNT);
  assign count    = ram_count_q + CW'(rd_pend_q) + CW'(obuf_occ);
  assign empty    = (count == '0);

  // Access arbitration: a read is issued only if its word is guaranteed a slot
  always_comb begin
    pop       = rd_valid && rd_ready;
    rd_issue  = !rst && !flush && (ram_count_q != '0) &&
                ((3'(obuf_occ) + 3'(rd_pend_q)) < (3'(OBUF_DEPTH) + 3'(pop)));
    wr_ready  = !rst && !flush && !full && !rd_issue;
    wr_accept = wr_valid && wr_ready;
    ram_op    = rd_issue ? RAM_READ : (wr_accept ? RAM_WRITE : RAM_IDLE);

    ram_en   = (ram_op != RAM_IDLE);
    ram_we   = (ram_op == RAM_WRITE);
    ram_addr = addr_q;
    ram_din  = din_q;
    case (ram_op)
      RAM_WRITE: begin
        ram_addr = wr_ptr_q;
        ram_din  = wr_data;
      end
      RAM_READ: ram_addr = rd_ptr_q;
      default: ;
    endcase
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_count_d = ram_count_q;
    rd_pend_d   = 1'b0;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      ram_count_d = '0;
    end else begin
      case (ram_op)
        RAM_WRITE: begin
          wr_ptr_d    = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
          ram_count_d = ram_count_q + CW'(1);
        end
        RAM_READ: begin
          rd_ptr_d    = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
          ram_count_d = ram_count_q - CW'(1);
          rd_pend_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      rd_pend_q   <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      rd_pend_q   <= rd_pend_d;
      addr_q      <= ram_addr;
      din_q       <= ram_din;
    end
  end

  // Returning RAM data is dropped when a flush lands on its capture cycle
  cdnsusbhs_adma_buf_obuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_obuf (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (rd_pend_q && !flush),
    .push_data(ram_dout),
    .pop      (pop && !flush),
    .occ      (obuf_occ),
    .head     (rd_data)
  );

endmodule

// File: tb/tb_cdnsusbhs_adma_buf_ctrl.sv
// Bench for the ADMA buffer controller: behavioural RAM plus a word-queue
// model of everything the block holds, driven by scenario tasks.
module tb_cdnsusbhs_adma_buf_ctrl;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned CW = AW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid, wr_ready, rd_valid, rd_ready, flush;
  logic [DW-1:0] wr_data, rd_data, ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic [CW-1:0] count;
  logic          full, empty, ram_we, ram_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] mem [DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] model_q [$];
  logic          s_rv, s_empty, s_full, s_wr_ready, s_acc, s_pop, s_ram_en, s_ram_we;
  logic [DW-1:0] s_rd, s_exp, s_ram_din;
  logic [CW-1:0] s_count;
  logic [AW-1:0] s_ram_addr;
  int            s_size;

  cdnsusbhs_adma_buf_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEMORY_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready), .flush(flush),
    .count(count), .full(full), .empty(empty), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_en(ram_en), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read data
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout <= mem[ram_addr];
    end
  end

  // One clock: drive inputs, sample before the rising edge, update the word queue
  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr, input logic fl);
    wr_valid = wv; wr_data = wd; rd_ready = rr; flush = fl;
    #1;
    s_rv = rd_valid; s_rd = rd_data; s_count = count; s_empty = empty; s_full = full;
    s_wr_ready = wr_ready; s_ram_en = ram_en; s_ram_we = ram_we;
    s_ram_addr = ram_addr; s_ram_din = ram_din;
    s_size = model_q.size();
    s_acc  = wv && wr_ready;
    s_pop  = rd_valid && rr && !fl;
    s_exp  = (model_q.size() > 0) ? model_q[0] : '0;
    if (fl) begin
      model_q.delete();
    end else begin
      if (s_pop && model_q.size() > 0) void'(model_q.pop_front());
      if (s_acc) model_q.push_back(wd);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b1; wr_data = 32'hFFFF_FFFF; rd_ready = 1'b1; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (wr_ready !== 1'b0) begin n_errors++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); end
    n_checks++; if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    n_checks++; if ({ram_en, ram_we} !== 2'b00) begin n_errors++; $display("FAIL reset_ram_ctl: got %b expected 00", {ram_en, ram_we}); end
    n_checks++; if (ram_addr !== '0 || ram_din !== '0) begin n_errors++; $display("FAIL reset_ram_bus: got addr %0h din %0h expected 0 0", ram_addr, ram_din); end
    n_checks++; if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin n_errors++; $display("FAIL reset_status: got count %0d empty %b full %b expected 0 1 0", count, empty, full); end
    @(negedge clk);
    rst = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    #1;
    n_checks++; if (wr_ready !== 1'b1) begin n_errors++; $display("FAIL release_wr_ready: got %b expected 1", wr_ready); end
    model_q.delete();
  endtask

  task automatic test_single_latency();
    int seen_at = -1;
    for (int k = 0; k < 6; k++) begin
      step(k == 0, 32'hA5A5_0001, 1'b1, 1'b0);
      if (k == 0) begin
        n_checks++; if (s_acc !== 1'b1) begin n_errors++; $display("FAIL single_accept: got %b expected 1", s_acc); end
      end
      n_checks++; if (s_count !== CW'(s_size)) begin n_errors++; $display("FAIL single_count c%0d: got %0d expected %0d", k, s_count, s_size); end
      if (s_rv && seen_at < 0) begin
        seen_at = k;
        n_checks++; if (s_rd !== 32'hA5A5_0001) begin n_errors++; $display("FAIL single_data: got %h expected a5a50001", s_rd); end
      end
    end
    n_checks++; if (seen_at != 3) begin n_errors++; $display("FAIL single_latency: got cycle %0d expected 3", seen_at); end
    n_checks++; if (s_empty !== 1'b1 || s_count !== '0) begin n_errors++; $display("FAIL single_empty_after: got empty %b count %0d expected 1 0", s_empty, s_count); end
  endtask

  task automatic test_fill_full();
    int            accepted = 0;
    logic [DW-1:0] first_word = '0;
    for (int c = 0; c < 200; c++) begin
      step(1'b1, $urandom, 1'b0, 1'b0);
      if (s_acc) begin
        if (accepted == 0) first_word = model_q[0];
        accepted++;
      end
      n_checks++; if (s_count !== CW'(s_size)) begin n_errors++; $display("FAIL fill_count: got %0d expected %0d", s_count, s_size); end
    end
    step(1'b1, 32'h0, 1'b0, 1'b0);
    n_checks++; if (accepted != DEPTH + 2) begin n_errors++; $display("FAIL fill_accepted: got %0d expected %0d", accepted, DEPTH + 2); end
    n_checks++; if (s_count !== CW'(DEPTH + 2)) begin n_errors++; $display("FAIL fill_final_count: got %0d expected %0d", s_count, DEPTH + 2); end
    n_checks++; if (s_full !== 1'b1 || s_wr_ready !== 1'b0) begin n_errors++; $display("FAIL fill_full: got full %b wr_ready %b expected 1 0", s_full, s_wr_ready); end
    n_checks++; if (s_rv !== 1'b1 || s_rd !== first_word) begin n_errors++; $display("FAIL fill_head: got valid %b data %h expected 1 %h", s_rv, s_rd, first_word); end
    for (int c = 0; c < 1000 && model_q.size() > 0; c++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (s_pop) begin
        n_checks++; if (s_rd !== s_exp) begin n_errors++; $display("FAIL fill_drain_data: got %h expected %h", s_rd, s_exp); end
      end
    end
    n_checks++; if (model_q.size() != 0) begin n_errors++; $display("FAIL fill_drain_timeout: got %0d left expected 0", model_q.size()); end
  endtask

  task automatic test_stream();
    int sent = 0;
    int got  = 0;
    for (int c = 0; c < 3000 && got < 300; c++) begin
      step(sent < 300, 32'h5000_0000 + 32'(sent), 1'b1, 1'b0);
      if (s_acc) sent++;
      if (s_pop) begin
        n_checks++; if (s_rd !== 32'h5000_0000 + 32'(got)) begin n_errors++; $display("FAIL stream_data: got %h expected %h", s_rd, 32'h5000_0000 + 32'(got)); end
        got++;
      end
      n_checks++; if (s_count !== CW'(s_size)) begin n_errors++; $display("FAIL stream_count: got %0d expected %0d", s_count, s_size); end
    end
    n_checks++; if (got != 300 || sent != 300) begin n_errors++; $display("FAIL stream_total: got %0d/%0d expected 300/300", got, sent); end
  endtask

  task automatic test_stall_toggle();
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    int            n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      step(1'b1, 32'h7000_0000 + 32'(n), 1'b0, 1'b0);
      if (s_acc) n++;
    end
    repeat (4) step(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (s_count !== 4 || s_rv !== 1'b1) begin n_errors++; $display("FAIL stall_prefill: got count %0d valid %b expected 4 1", s_count, s_rv); end
    for (int c = 0; c < 60; c++) begin
      step(1'b1, 32'h7000_0000 + 32'(n), c[0], 1'b0);
      if (s_acc) n++;
      if (prev_stall) begin
        n_checks++; if (s_rv !== 1'b1 || s_rd !== prev_data) begin n_errors++; $display("FAIL stall_hold: got valid %b data %h expected 1 %h", s_rv, s_rd, prev_data); end
      end
      if (s_pop) begin
        n_checks++; if (s_rd !== s_exp) begin n_errors++; $display("FAIL stall_data: got %h expected %h", s_rd, s_exp); end
      end
      n_checks++; if (s_count !== CW'(s_size)) begin n_errors++; $display("FAIL stall_count: got %0d expected %0d", s_count, s_size); end
      prev_stall = s_rv && !c[0];
      prev_data  = s_rd;
    end
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_flush_inflight();
    logic got = 1'b0;
    step(1'b1, 32'hF100_0001, 1'b0, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 32'hF100_0002, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (s_ram_en !== 1'b1 || s_ram_we !== 1'b0) begin n_errors++; $display("FAIL flush_read_issue: got en %b we %b expected 1 0", s_ram_en, s_ram_we); end
    step(1'b1, 32'hF100_0003, 1'b1, 1'b1);
    n_checks++; if (s_count !== 2) begin n_errors++; $display("FAIL flush_pre_count: got %0d expected 2", s_count); end
    n_checks++; if (s_wr_ready !== 1'b0 || s_ram_en !== 1'b0) begin n_errors++; $display("FAIL flush_no_access: got wr_ready %b ram_en %b expected 0 0", s_wr_ready, s_ram_en); end
    for (int k = 0; k < 5; k++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n_checks++; if (s_count !== '0 || s_empty !== 1'b1 || s_rv !== 1'b0) begin n_errors++; $display("FAIL flush_after c%0d: got count %0d empty %b valid %b expected 0 1 0", k, s_count, s_empty, s_rv); end
    end
    for (int k = 0; k < 10 && !got; k++) begin
      step(k == 0, 32'hF100_0004, 1'b1, 1'b0);
      if (s_pop) begin
        got = 1'b1;
        n_checks++; if (s_rd !== 32'hF100_0004) begin n_errors++; $display("FAIL flush_next_data: got %h expected f1000004", s_rd); end
      end
    end
    n_checks++; if (!got) begin n_errors++; $display("FAIL flush_next_timeout: got none expected f1000004"); end
  endtask

  task automatic test_random();
    logic          have_prev = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_din  = '0;
    for (int c = 0; c < 800; c++) begin
      step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 79) == 0));
      if (s_pop) begin
        n_checks++; if (s_rd !== s_exp) begin n_errors++; $display("FAIL rand_data: got %h expected %h", s_rd, s_exp); end
      end
      n_checks++; if (s_count !== CW'(s_size) || s_empty !== (s_size == 0)) begin n_errors++; $display("FAIL rand_count: got %0d empty %b expected %0d", s_count, s_empty, s_size); end
      if (have_prev && !s_ram_en) begin
        n_checks++; if (s_ram_addr !== prev_addr || s_ram_din !== prev_din) begin n_errors++; $display("FAIL rand_idle_hold: got %0h/%h expected %0h/%h", s_ram_addr, s_ram_din, prev_addr, prev_din); end
      end
      have_prev = 1'b1; prev_addr = s_ram_addr; prev_din = s_ram_din;
    end
    for (int c = 0; c < 1000 && model_q.size() > 0; c++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (s_pop) begin
        n_checks++; if (s_rd !== s_exp) begin n_errors++; $display("FAIL rand_drain_data: got %h expected %h", s_rd, s_exp); end
      end
    end
    n_checks++; if (model_q.size() != 0) begin n_errors++; $display("FAIL rand_drain_timeout: got %0d left expected 0", model_q.size()); end
  endtask

  task automatic test_async_reset();
    int seen_at = -1;
    for (int i = 0; i < 8; i++) step(1'b1, 32'hB000_0000 + 32'(i), 1'b1, 1'b0);
    wr_valid = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (rd_valid !== 1'b0 || wr_ready !== 1'b0) begin n_errors++; $display("FAIL arst_handshake: got rd_valid %b wr_ready %b expected 0 0", rd_valid, wr_ready); end
    n_checks++; if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin n_errors++; $display("FAIL arst_status: got count %0d empty %b full %b expected 0 1 0", count, empty, full); end
    n_checks++; if ({ram_en, ram_we} !== 2'b00 || ram_addr !== '0 || ram_din !== '0) begin n_errors++; $display("FAIL arst_ram: got en/we %b addr %0h din %h expected 00 0 0", {ram_en, ram_we}, ram_addr, ram_din); end
    @(negedge clk);
    rst = 1'b0; wr_valid = 1'b0;
    model_q.delete();
    for (int k = 0; k < 10 && seen_at < 0; k++) begin
      step(k == 0, 32'hC0DE_0001, 1'b1, 1'b0);
      if (k == 0) begin
        n_checks++; if (s_wr_ready !== 1'b1) begin n_errors++; $display("FAIL arst_first_ready: got %b expected 1", s_wr_ready); end
      end
      if (s_pop) begin
        seen_at = k;
        n_checks++; if (s_rd !== 32'hC0DE_0001) begin n_errors++; $display("FAIL arst_readback: got %h expected c0de0001", s_rd); end
      end
    end
    n_checks++; if (seen_at != 3) begin n_errors++; $display("FAIL arst_latency: got cycle %0d expected 3", seen_at); end
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0; flush = 1'b0;
    test_reset();
    test_single_latency();
    test_fill_full();
    test_stream();
    test_stall_toggle();
    test_flush_inflight();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
